// File: rtl/eon_mem_pkg.sv
// Shared types and lane/extension helpers for the data-memory responder.
// Helpers assume a 32-bit word split into four byte lanes.
package eon_mem_pkg;

  typedef enum logic [2:0] {
    MODE_B  = 3'b000,
    MODE_H  = 3'b001,
    MODE_W  = 3'b010,
    MODE_BU = 3'b100,
    MODE_HU = 3'b101
  } addrMode_e;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } respState_e;

  function automatic logic [3:0] lane_en(input logic [2:0] mode, input logic [1:0] a);
    case (mode)
      MODE_B, MODE_BU: lane_en = 4'b0001 << a;
      MODE_H, MODE_HU: lane_en = 4'b0011 << {a[1], 1'b0};
      MODE_W:          lane_en = 4'b1111;
      default:         lane_en = 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] mode, input logic [1:0] a,
                                              input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{a, 3'b000} +: 8];
    h = w[{a[1], 4'b0000} +: 16];
    case (mode)
      MODE_B:  load_extend = {{24{b[7]}}, b};
      MODE_BU: load_extend = {24'b0, b};
      MODE_H:  load_extend = {{16{h[15]}}, h};
      MODE_HU: load_extend = {16'b0, h};
      MODE_W:  load_extend = w;
      default: load_extend = 32'b0;
    endcase
  endfunction

  // Misaligned, undefined func3, or an unsigned variant used for a store.
  function automatic logic access_error(input logic [2:0] mode, input logic [1:0] a,
                                        input logic wr);
    case (mode)
      MODE_B:  access_error = 1'b0;
      MODE_BU: access_error = wr;
      MODE_H:  access_error = a[0];
      MODE_HU: access_error = a[0] | wr;
      MODE_W:  access_error = (a != 2'b00);
      default: access_error = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word RAM: byte-lane synchronous write, combinational read.
module dmem_array #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic [3:0]    i_we,
  input  logic [AW-1:0] i_idx,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    for (int i = 0; i < 4; i++) begin
      if (i_we[i]) r_mem[i_idx][8*i +: 8] <= i_wdata[8*i +: 8];
    end
  end

  assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/dmem_responder.sv
// Timed, handshaked data-memory responder: IDLE -> WAIT(waitStates) -> RESP,
// with byte/half/word access, RISC-V load extension and error signalling.
module dmem_responder
  import eon_mem_pkg::*;
#(
  parameter int width      = 32,
  parameter int depthWords = 1024,
  parameter int waitStates = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             read,
  input  logic             write,
  input  logic [width-1:0] address,
  input  logic [width-1:0] data,
  input  logic [2:0]       addressMode,
  output logic [width-1:0] dataOut,
  output logic             respValid,
  output logic             stallOut,
  output logic             error
);

  localparam int AW = $clog2(depthWords);
  localparam logic [3:0] CNT_INIT = (waitStates == 0) ? 4'd0 : 4'(waitStates - 1);

  respState_e       r_state;
  logic [3:0]       r_cnt;
  logic [width-1:0] r_addr;
  logic [width-1:0] r_data;
  logic [2:0]       r_mode;
  logic             r_wr;
  logic             r_err;

  logic             w_req;
  logic             w_idle;
  logic [width-1:0] w_addr;
  logic [2:0]       w_mode;
  logic             w_wr;
  logic             w_err;
  logic [AW-1:0]    w_idx;
  logic [3:0]       w_we;
  logic [width-1:0] w_wdata;
  logic [width-1:0] w_rdata;
  logic [width-1:0] w_load;

  assign w_req  = read | write;
  assign w_idle = (r_state == IDLE);

  // In IDLE the live inputs drive the RAM so a zero-wait access can respond next cycle.
  assign w_addr  = w_idle ? address : r_addr;
  assign w_mode  = w_idle ? addressMode : r_mode;
  assign w_wr    = w_idle ? write : r_wr;
  assign w_err   = w_idle ? access_error(addressMode, address[1:0], write) : r_err;
  assign w_idx   = w_addr[AW+1:2];
  assign w_we    = (r_state == RESP && r_wr && !r_err) ? lane_en(r_mode, r_addr[1:0]) : 4'b0000;
  assign w_wdata = r_data << {r_addr[1:0], 3'b000};
  assign w_load  = (w_err || w_wr) ? '0 : load_extend(w_mode, w_addr[1:0], w_rdata);

  assign stallOut = w_req && (r_state != RESP) && !rst;

  dmem_array #(.DEPTH(depthWords)) u_array (
    .i_clk   (clk),
    .i_we    (w_we),
    .i_idx   (w_idx),
    .i_wdata (w_wdata),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk) begin
    if (w_idle && w_req) begin
      r_addr <= address;
      r_data <= data;
      r_mode <= addressMode;
      r_wr   <= write;
      r_err  <= access_error(addressMode, address[1:0], write);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= 4'd0;
      dataOut   <= '0;
      respValid <= 1'b0;
      error     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          respValid <= 1'b0;
          if (w_req) begin
            if (waitStates == 0) begin
              r_state   <= RESP;
              respValid <= 1'b1;
              dataOut   <= w_load;
              error     <= w_err;
            end else begin
              r_state <= WAIT;
              r_cnt   <= CNT_INIT;
            end
          end
        end
        WAIT: begin
          if (!w_req) begin
            r_state <= IDLE;
          end else if (r_cnt == 4'd0) begin
            r_state   <= RESP;
            respValid <= 1'b1;
            dataOut   <= w_load;
            error     <= w_err;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: begin
          r_state   <= IDLE;
          respValid <= 1'b0;
        end
      endcase
    end
  end

  // Requester must hold its request fields stable while the access is outstanding.
  a_hold_fields: assert property (@(posedge clk) disable iff (rst)
    (r_state != IDLE && w_req) |->
      (address == r_addr && data == r_data && addressMode == r_mode && write == r_wr));

endmodule

// File: tb/tb_dmem_responder.sv
// Directed plus randomized checks of dmem_responder against a byte-array memory model.
module tb_dmem_responder;
  import eon_mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdA, wrA, rdB, wrB;
  logic [31:0] adA, daA, adB, daB;
  logic [2:0]  mA, mB;
  logic [31:0] doA, doB;
  logic        rvA, stA, erA, rvB, stB, erB;

  int tests = 0;
  int fails = 0;
  logic [7:0] mdl [0:1][0:4095];

  always #5 clk = ~clk;

  dmem_responder #(.width(32), .depthWords(1024), .waitStates(2)) dutA (
    .clk(clk), .rst(rst), .read(rdA), .write(wrA), .address(adA), .data(daA),
    .addressMode(mA), .dataOut(doA), .respValid(rvA), .stallOut(stA), .error(erA));

  dmem_responder #(.width(32), .depthWords(1024), .waitStates(0)) dutB (
    .clk(clk), .rst(rst), .read(rdB), .write(wrB), .address(adB), .data(daB),
    .addressMode(mB), .dataOut(doB), .respValid(rvB), .stallOut(stB), .error(erB));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit exp_err(input bit wr, input logic [2:0] m, input logic [31:0] a);
    if (m == 3'd3 || m == 3'd6 || m == 3'd7) return 1'b1;
    if (wr && (m == 3'd4 || m == 3'd5)) return 1'b1;
    if ((m == 3'd1 || m == 3'd5) && a[0]) return 1'b1;
    if (m == 3'd2 && (a % 4) != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_load(input int s, input logic [2:0] m, input logic [31:0] a);
    int base;
    logic [7:0]  b;
    logic [15:0] h;
    base = int'(a % 4096);
    b = mdl[s][base];
    h = {mdl[s][(base + 1) % 4096], mdl[s][base]};
    case (m)
      3'd0: return {{24{b[7]}}, b};
      3'd4: return {24'd0, b};
      3'd1: return {{16{h[15]}}, h};
      3'd5: return {16'd0, h};
      default: return {mdl[s][base + 3], mdl[s][base + 2], mdl[s][base + 1], mdl[s][base]};
    endcase
  endfunction

  task automatic model_store(input int s, input logic [2:0] m, input logic [31:0] a,
                             input logic [31:0] d);
    int n;
    n = (m == 3'd0) ? 1 : (m == 3'd1) ? 2 : 4;
    for (int i = 0; i < n; i++) mdl[s][int'((a + 32'(i)) % 4096)] = d[8*i +: 8];
  endtask

  task automatic access(input int s, input bit wr, input bit rd, input logic [2:0] m,
                        input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] dout, output logic eo, output int sc, output int lat);
    if (s == 0) begin wrA = wr; rdA = rd; mA = m; adA = a; daA = d; end
    else        begin wrB = wr; rdB = rd; mB = m; adB = a; daB = d; end
    lat = -1; sc = 0; dout = 32'hx; eo = 1'bx;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if ((s == 0) ? stA : stB) sc++;
      if ((s == 0) ? rvA : rvB) begin
        lat  = c;
        dout = (s == 0) ? doA : doB;
        eo   = (s == 0) ? erA : erB;
        break;
      end
    end
    @(posedge clk); #1;
    if (s == 0) begin wrA = 1'b0; rdA = 1'b0; end
    else        begin wrB = 1'b0; rdB = 1'b0; end
  endtask

  task automatic txn(input int s, input bit wr, input bit rd, input logic [2:0] m,
                     input logic [31:0] a, input logic [31:0] d, input string tag,
                     output logic [31:0] dout);
    int ws, sc, lat;
    bit e;
    logic eo;
    logic [31:0] ed;
    ws = (s == 0) ? 2 : 0;
    e  = exp_err(wr, m, a);
    ed = (e || wr) ? 32'd0 : model_load(s, m, a);
    access(s, wr, rd, m, a, d, dout, eo, sc, lat);
    check({tag, "_lat"}, 32'(lat), 32'(ws + 1));
    check({tag, "_stall"}, 32'(sc), 32'(ws + 1));
    check({tag, "_err"}, {31'd0, eo}, {31'd0, e});
    if (!wr) check({tag, "_data"}, dout, ed);
    if (wr && !e) model_store(s, m, a, d);
  endtask

  initial begin
    logic [31:0] r;
    bit wr, rd;
    rst = 1'b1;
    rdA = 0; wrA = 0; adA = 0; daA = 0; mA = 3'd2;
    rdB = 0; wrB = 0; adB = 0; daB = 0; mB = 3'd2;
    repeat (2) @(negedge clk);
    check("rst_dout", doA, 32'd0);
    check("rst_rv", {31'd0, rvA}, 32'd0);
    check("rst_err", {31'd0, erA}, 32'd0);
    check("rst_stall", {31'd0, stA}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 16; i++) txn(0, 1, 0, 3'd2, 32'(4 * i), $urandom, "init", r);

    txn(0, 1, 0, 3'd2, 32'h10, 32'hDEADBEEF, "sw10", r);
    txn(0, 0, 1, 3'd2, 32'h10, 32'h0, "lw10", r);
    check("lw10_const", r, 32'hDEADBEEF);
    txn(0, 1, 0, 3'd0, 32'h11, 32'h80, "sb11", r);
    txn(0, 0, 1, 3'd0, 32'h11, 32'h0, "lb11", r);
    check("lb11_const", r, 32'hFFFFFF80);
    txn(0, 0, 1, 3'd4, 32'h11, 32'h0, "lbu11", r);
    check("lbu11_const", r, 32'h00000080);
    txn(0, 0, 1, 3'd2, 32'h10, 32'h0, "lw10b", r);
    check("lw10b_const", r, 32'hDEAD80EF);
    @(negedge clk);
    check("dout_hold", doA, 32'hDEAD80EF);
    @(posedge clk); #1;
    txn(0, 1, 0, 3'd1, 32'h12, 32'h1234, "sh12", r);
    txn(0, 0, 1, 3'd5, 32'h12, 32'h0, "lhu12", r);
    check("lhu12_const", r, 32'h00001234);
    txn(0, 0, 1, 3'd1, 32'h13, 32'h0, "lh13_mis", r);
    txn(0, 1, 0, 3'd4, 32'h10, 32'hFF, "sbu_err", r);
    txn(0, 1, 0, 3'd2, 32'h12, 32'h0, "sw_mis", r);
    txn(0, 0, 1, 3'd3, 32'h10, 32'h0, "mode3", r);
    txn(0, 0, 1, 3'd2, 32'h10, 32'h0, "lw10c", r);
    check("lw10c_const", r, 32'h123480EF);

    // Read withdrawn after one WAIT cycle.
    rdA = 1'b1; mA = 3'd2; adA = 32'h10;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rdA = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_rv", {31'd0, rvA}, 32'd0);
      check("abort_stall", {31'd0, stA}, 32'd0);
    end
    @(posedge clk); #1;
    txn(0, 0, 1, 3'd2, 32'h10, 32'h0, "lw_after_abort", r);

    // Reset during WAIT of a store.
    txn(0, 1, 0, 3'd2, 32'h20, 32'hCAFEF00D, "sw20", r);
    txn(0, 0, 1, 3'd2, 32'h10, 32'h0, "lw10d", r);
    wrA = 1'b1; mA = 3'd2; adA = 32'h20; daA = 32'h55;
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("midrst_dout", doA, 32'd0);
    check("midrst_rv", {31'd0, rvA}, 32'd0);
    check("midrst_err", {31'd0, erA}, 32'd0);
    check("midrst_stall", {31'd0, stA}, 32'd0);
    wrA = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    txn(0, 0, 1, 3'd2, 32'h20, 32'h0, "lw20", r);
    check("lw20_const", r, 32'hCAFEF00D);

    for (int i = 0; i < 30; i++) begin
      wr = 1'($urandom_range(0, 1));
      rd = wr ? 1'($urandom_range(0, 1)) : 1'b1;
      txn(0, wr, rd, 3'($urandom_range(0, 7)),
          32'($urandom_range(0, 63)) | (32'($urandom_range(0, 3)) << 12), $urandom, "rand", r);
    end

    txn(1, 1, 0, 3'd2, 32'h4, 32'h0BADF00D, "z_sw4", r);
    txn(1, 0, 1, 3'd2, 32'h4, 32'h0, "z_lw4", r);
    txn(1, 0, 1, 3'd2, 32'h1004, 32'h0, "z_alias", r);
    check("z_alias_const", r, 32'h0BADF00D);
    txn(1, 1, 0, 3'd0, 32'h1006, 32'hA5, "z_sb_alias", r);
    txn(1, 0, 1, 3'd4, 32'h6, 32'h0, "z_lbu6", r);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
